traffic_phase_ctrl: RTL and testbench
=====================================

# traffic_phase_ctrl

Clocked sequencer that drives the combinational `traffic_light` decoder. It steps the four-phase cycle RED → YELLOW → GREEN → YELLOW, times each phase in ticks from a strobe, and extends GREEN while traffic is heavy. It also latches the line sensor during yellow phases. It produces the `counter`, `line_sen` and `car_num` values that `traffic_light` consumes, replacing the bench-driven stimulus with synthesizable control.

## Interface
- `RED_TICKS`, 10: RED dwell in ticks, ≥1
- `GREEN_TICKS`, 10: GREEN dwell per grant or extension, ≥1
- `YELLOW_TICKS`, 2: dwell of each YELLOW phase, ≥1
- `MAX_EXT`, 4: maximum consecutive GREEN extensions, 0–7
- `CAR_THRESH`, 10: extension granted when `car_num` > `CAR_THRESH`
- `clk` in 1: single system clock
- `rst_n` in 1: reset, asynchronous, active-low
- `tick` in 1: 1 ms timing strobe, one `clk` wide; dwell advances only on `tick`
- `enable` in 1: 0 freezes all state; outputs hold
- `car_num_in` in 32: current queued-car count, unsigned
- `line_sen_in` in 1: raw stop-line sensor, synchronous to `clk`
- `counter` out 32: phase index to `traffic_light.counter`; phase = `counter[1:0]`
- `car_num` out 32: registered copy of `car_num_in` to `traffic_light.car_num`
- `line_sen` out 1: latched sensor to `traffic_light.line_sen`
- `phase` out 2: 0 RED, 1 YEL1, 2 GRN, 3 YEL2 (equals `counter[1:0]`)
- `phase_start` out 1: one-cycle pulse on each phase entry and each GREEN extension
- `ext_cnt` out 3: extensions granted in the current GREEN

## Operation
- The state is `counter`, a dwell counter `dwell` and `ext_cnt`. Phase is always `counter[1:0]`; there is no separate FSM register.
- Phase order: RED(0) → YEL1(1) → GRN(2) → YEL2(3) → RED. `counter` increments by 1 per phase change.
- At 2^32 − 1, `counter` wraps to 0 and the phase stays consistent.
- Dwell limit: `RED_TICKS`, `YELLOW_TICKS`, `GREEN_TICKS` or `YELLOW_TICKS` for phases 0–3 respectively.
- On `enable && tick`:
  - If `dwell` is not equal to limit − 1, `dwell` increments.
  - Otherwise `dwell` is set to 0 and the end-of-phase action occurs.
- End of GRN, extension granted (`ext_cnt < MAX_EXT` and `car_num > CAR_THRESH`, using the registered value): `ext_cnt` increments, `counter` is unchanged, GREEN restarts and `phase_start` pulses.
- End of GRN, extension not granted: `ext_cnt` is set to 0 and `counter` increments.
- End of any other phase: `counter` increments.
- `car_num` register: updated every cycle from `car_num_in` when `enable` = 1.
- `line_sen` in phases 1 and 3: set when `line_sen_in` = 1. It is sticky until the phase ends.
- `line_sen` in phases 0 and 2: held at 0; `line_sen_in` is ignored.
- Clear has priority: on the edge that leaves a yellow phase, `line_sen` goes to 0 even if `line_sen_in` = 1.
- `enable` = 0: no updates, including `car_num` and `line_sen`; `phase_start` = 0.
- Reset values: `counter` = 0 (RED), `dwell` = 0, `ext_cnt` = 0, `car_num` = 0, `line_sen` = 0, `phase_start` = 0.
- Reset asserted mid-phase returns to RED immediately; no partial GREEN carries over.

## Timing
- Phase duration is exactly limit ticks.
- The transition edge is the `clk` edge that samples the limit-th tick; `counter` and `phase` change on that edge.
- `phase_start` is asserted in the cycle after that edge.
- Only ticks are counted; any number of idle cycles between ticks is allowed.
- Extension decision: uses the `car_num` registered value at the final GREEN tick. Latency from `car_num_in` to decision is 1 cycle.
- `line_sen` latency: 1 cycle from `line_sen_in`.
- Deassertion of `rst_n` is synchronized externally. The first tick after release counts as RED tick 1.
- Worst-case GREEN length: `GREEN_TICKS` × (`MAX_EXT` + 1).

## Structure
- Package `traffic_pkg`:
  - Phase constants `PH_RED` = 0, `PH_YEL1` = 1, `PH_GRN` = 2, `PH_YEL2` = 3.
  - Default dwell constants 10/10/2.
  - `MAX_EXT`/`CAR_THRESH` defaults.
- Sub-module `tl_dwell_timer`:
  - Parameterised tick counter with `load`, `limit` and `done` (asserted on the final tick).
  - The controller owns the phase/extension decisions and the sensor latch.
- The top level of the demo instantiates `traffic_phase_ctrl` feeding `traffic_light`.

## Test plan
- Base cycle:
  - Stimulus: `tick` every cycle, `car_num_in` = 0, `enable` = 1.
  - Required: `counter` becomes 1, 2, 3, 4 at ticks 10, 12, 22, 24; `phase_start` pulses at each; `ext_cnt` stays 0.
- Extension cap:
  - Stimulus: `car_num_in` = 20 held.
  - Required: GRN lasts 50 ticks; `ext_cnt` steps 1..4 at ticks 10, 20, 30, 40 of GRN, then returns to 0 as `counter` goes 2 → 3.
- Threshold boundary:
  - Stimulus: `car_num_in` = 10, then `car_num_in` = 11 in a later cycle.
  - Required: at 10, no extension and GRN lasts 10 ticks; at 11, GRN extends.
- Sensor latch:
  - Stimulus: 1-cycle `line_sen_in` pulses in RED, in YEL1 tick 1 and on the last YEL1 tick edge.
  - Required: RED pulse ignored; `line_sen` = 1 from the next cycle to the end of YEL1; 0 in GRN.
- Gating:
  - Stimulus: `tick` every 5th cycle, and `enable` = 0 for 7 cycles mid-RED.
  - Required: durations are counted in ticks only; all outputs frozen while disabled.
- Reset mid-GRN:
  - Stimulus: `rst_n` low for 3 cycles while `ext_cnt` = 2.
  - Required: `counter`, `ext_cnt`, `line_sen` and `car_num` read 0 before the next `clk` edge; the cycle restarts at RED tick 1.

Source files
------------

// File: rtl/traffic_pkg.sv
// Shared phase encodings, default dwell times and the per-phase dwell limit lookup.
package traffic_pkg;

    localparam logic [1:0] PH_RED  = 2'd0;
    localparam logic [1:0] PH_YEL1 = 2'd1;
    localparam logic [1:0] PH_GRN  = 2'd2;
    localparam logic [1:0] PH_YEL2 = 2'd3;

    localparam int unsigned RED_TICKS_DEF    = 10;
    localparam int unsigned GREEN_TICKS_DEF  = 10;
    localparam int unsigned YELLOW_TICKS_DEF = 2;
    localparam int unsigned MAX_EXT_DEF      = 4;
    localparam int unsigned CAR_THRESH_DEF   = 10;

    localparam int unsigned DWELL_W = 32;

    // Dwell length in ticks for a given phase; both yellows share one limit.
    function automatic logic [DWELL_W-1:0] phase_limit(
        input logic [1:0]         ph,
        input logic [DWELL_W-1:0] red_ticks,
        input logic [DWELL_W-1:0] grn_ticks,
        input logic [DWELL_W-1:0] yel_ticks
    );
        logic [DWELL_W-1:0] lim;
        case (ph)
            PH_RED:  lim = red_ticks;
            PH_GRN:  lim = grn_ticks;
            default: lim = yel_ticks;
        endcase
        return lim;
    endfunction

endpackage

// File: rtl/tl_dwell_timer.sv
// Tick counter for one phase dwell: counts 0..limit-1 and flags the final tick.
module tl_dwell_timer
    import traffic_pkg::*;
#(
    parameter int unsigned W = DWELL_W
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_load,
    input  logic         i_tick,
    input  logic [W-1:0] i_limit,
    output logic         o_done
);

    logic [W-1:0] r_dwell;
    logic [W-1:0] w_dwell_d;

    // Final tick of the dwell: the caller performs the end-of-phase action on this edge.
    assign o_done = i_tick && (r_dwell == i_limit - W'(1));

    // Next dwell: load restarts the count, otherwise advance or wrap on each tick.
    always_comb begin
        w_dwell_d = r_dwell;
        if (i_load) begin
            w_dwell_d = '0;
        end else if (i_tick) begin
            w_dwell_d = o_done ? '0 : r_dwell + W'(1);
        end
    end

    // Dwell state register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_dwell <= '0;
        end else begin
            r_dwell <= w_dwell_d;
        end
    end

endmodule

// File: rtl/traffic_phase_ctrl.sv
// Four-phase traffic sequencer: RED -> YEL1 -> GRN -> YEL2, tick-timed dwells,
// GREEN extension under heavy traffic and a yellow-phase stop-line latch.
module traffic_phase_ctrl
    import traffic_pkg::*;
#(
    parameter int unsigned RED_TICKS    = RED_TICKS_DEF,
    parameter int unsigned GREEN_TICKS  = GREEN_TICKS_DEF,
    parameter int unsigned YELLOW_TICKS = YELLOW_TICKS_DEF,
    parameter int unsigned MAX_EXT      = MAX_EXT_DEF,
    parameter int unsigned CAR_THRESH   = CAR_THRESH_DEF
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_tick,
    input  logic        i_enable,
    input  logic [31:0] i_car_num_in,
    input  logic        i_line_sen_in,
    output logic [31:0] o_counter,
    output logic [31:0] o_car_num,
    output logic        o_line_sen,
    output logic [1:0]  o_phase,
    output logic        o_phase_start,
    output logic [2:0]  o_ext_cnt
);

    logic [31:0] r_counter;
    logic [31:0] r_car_num;
    logic        r_line_sen;
    logic        r_phase_start;
    logic [2:0]  r_ext_cnt;

    logic [31:0] w_counter_d;
    logic [31:0] w_car_num_d;
    logic        w_line_sen_d;
    logic        w_phase_start_d;
    logic [2:0]  w_ext_cnt_d;

    logic [1:0]         w_phase;
    logic [DWELL_W-1:0] w_limit;
    logic               w_tick_en;
    logic               w_done;
    logic               w_ext_ok;
    logic               w_yellow;

    // Phase is the low two bits of the counter, so wrap at 2^32-1 stays consistent.
    assign w_phase   = r_counter[1:0];
    assign w_yellow  = (w_phase == PH_YEL1) || (w_phase == PH_YEL2);
    assign w_tick_en = i_enable && i_tick;
    assign w_limit   = phase_limit(w_phase, DWELL_W'(RED_TICKS), DWELL_W'(GREEN_TICKS),
                                   DWELL_W'(YELLOW_TICKS));

    // Uses the registered car count so the decision sees a clean one-cycle-old sample.
    assign w_ext_ok = ({29'd0, r_ext_cnt} < 32'(MAX_EXT)) && (r_car_num > 32'(CAR_THRESH));

    // The dwell only restarts through its own wrap, so load is never needed here.
    tl_dwell_timer #(
        .W (DWELL_W)
    ) u_dwell (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_load  (1'b0),
        .i_tick  (w_tick_en),
        .i_limit (w_limit),
        .o_done  (w_done)
    );

    // Next-state: phase advance / GREEN extension, car sample and sensor latch.
    always_comb begin
        w_counter_d     = r_counter;
        w_ext_cnt_d     = r_ext_cnt;
        w_car_num_d     = r_car_num;
        w_line_sen_d    = r_line_sen;
        w_phase_start_d = 1'b0;
        if (i_enable) begin
            w_car_num_d = i_car_num_in;
            if (w_done) begin
                w_phase_start_d = 1'b1;
                if ((w_phase == PH_GRN) && w_ext_ok) begin
                    w_ext_cnt_d = r_ext_cnt + 3'd1;
                end else begin
                    w_counter_d = r_counter + 32'd1;
                    w_ext_cnt_d = 3'd0;
                end
            end
            // Clearing on the exit edge wins over a coincident sensor hit.
            if (!w_yellow || w_done) begin
                w_line_sen_d = 1'b0;
            end else if (i_line_sen_in) begin
                w_line_sen_d = 1'b1;
            end
        end
    end

    // Controller state registers; reset lands in RED with no extension history.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_counter     <= '0;
            r_ext_cnt     <= '0;
            r_car_num     <= '0;
            r_line_sen    <= 1'b0;
            r_phase_start <= 1'b0;
        end else begin
            r_counter     <= w_counter_d;
            r_ext_cnt     <= w_ext_cnt_d;
            r_car_num     <= w_car_num_d;
            r_line_sen    <= w_line_sen_d;
            r_phase_start <= w_phase_start_d;
        end
    end

    assign o_counter     = r_counter;
    assign o_car_num     = r_car_num;
    assign o_line_sen    = r_line_sen;
    assign o_phase       = w_phase;
    assign o_ext_cnt     = r_ext_cnt;
    // A pulse that lands in a disabled cycle is suppressed rather than held.
    assign o_phase_start = r_phase_start && i_enable;

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Directed bench for traffic_phase_ctrl with hand-computed expectations per scenario.
module tb_traffic_phase_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        tick;
    logic        enable;
    logic [31:0] car_num_in;
    logic        line_sen_in;
    logic [31:0] counter;
    logic [31:0] car_num;
    logic        line_sen;
    logic [1:0]  phase;
    logic        phase_start;
    logic [2:0]  ext_cnt;

    int pass_cnt  = 0;
    int total_cnt = 0;

    traffic_phase_ctrl #(
        .RED_TICKS    (10),
        .GREEN_TICKS  (10),
        .YELLOW_TICKS (2),
        .MAX_EXT      (4),
        .CAR_THRESH   (10)
    ) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_tick        (tick),
        .i_enable      (enable),
        .i_car_num_in  (car_num_in),
        .i_line_sen_in (line_sen_in),
        .o_counter     (counter),
        .o_car_num     (car_num),
        .o_line_sen    (line_sen),
        .o_phase       (phase),
        .o_phase_start (phase_start),
        .o_ext_cnt     (ext_cnt)
    );

    always #5 clk = ~clk;

    // One clock edge, then settle 1 time unit so outputs are sampled away from the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reset, then release just after an edge so the next edge samples tick 1.
    task automatic do_reset(input logic [31:0] car);
        rst_n       = 1'b0;
        tick        = 1'b0;
        enable      = 1'b1;
        line_sen_in = 1'b0;
        car_num_in  = car;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n       = 1'b0;
        tick        = 1'b1;
        enable      = 1'b1;
        car_num_in  = 32'd5;
        line_sen_in = 1'b1;
        step();
        step();
        total_cnt++;
        if (counter !== 32'd0) $display("FAIL reset.counter got=%0d exp=0", counter);
        else pass_cnt++;
        total_cnt++;
        if (car_num !== 32'd0) $display("FAIL reset.car_num got=%0d exp=0", car_num);
        else pass_cnt++;
        total_cnt++;
        if (line_sen !== 1'b0) $display("FAIL reset.line_sen got=%0b exp=0", line_sen);
        else pass_cnt++;
        total_cnt++;
        if (phase !== 2'd0) $display("FAIL reset.phase got=%0d exp=0", phase);
        else pass_cnt++;
        total_cnt++;
        if (phase_start !== 1'b0) $display("FAIL reset.phase_start got=%0b exp=0", phase_start);
        else pass_cnt++;
        total_cnt++;
        if (ext_cnt !== 3'd0) $display("FAIL reset.ext_cnt got=%0d exp=0", ext_cnt);
        else pass_cnt++;
        rst_n       = 1'b1;
        tick        = 1'b0;
        line_sen_in = 1'b0;
        car_num_in  = 32'd0;
    endtask

    task automatic test_base_cycle();
        logic [31:0] exp_cnt;
        logic        exp_ps;
        do_reset(32'd0);
        tick = 1'b1;
        for (int t = 1; t <= 25; t++) begin
            step();
            exp_cnt = (t < 10) ? 32'd0 : (t < 12) ? 32'd1 : (t < 22) ? 32'd2 :
                      (t < 24) ? 32'd3 : 32'd4;
            exp_ps  = (t == 10) || (t == 12) || (t == 22) || (t == 24);
            total_cnt++;
            if (counter !== exp_cnt)
                $display("FAIL base.counter t=%0d got=%0d exp=%0d", t, counter, exp_cnt);
            else pass_cnt++;
            total_cnt++;
            if (phase !== exp_cnt[1:0])
                $display("FAIL base.phase t=%0d got=%0d exp=%0d", t, phase, exp_cnt[1:0]);
            else pass_cnt++;
            total_cnt++;
            if (phase_start !== exp_ps)
                $display("FAIL base.phase_start t=%0d got=%0b exp=%0b", t, phase_start, exp_ps);
            else pass_cnt++;
            total_cnt++;
            if (ext_cnt !== 3'd0)
                $display("FAIL base.ext_cnt t=%0d got=%0d exp=0", t, ext_cnt);
            else pass_cnt++;
        end
        tick = 1'b0;
    endtask

    task automatic test_ext_cap();
        logic [31:0] exp_cnt;
        logic [2:0]  exp_ext;
        logic        exp_ps;
        do_reset(32'd20);
        tick = 1'b1;
        // GRN entered at edge 12; extensions at GRN ticks 10..40, exit at GRN tick 50.
        for (int t = 1; t <= 64; t++) begin
            step();
            exp_cnt = (t < 10) ? 32'd0 : (t < 12) ? 32'd1 : (t < 62) ? 32'd2 :
                      (t < 64) ? 32'd3 : 32'd4;
            exp_ext = (t < 22) ? 3'd0 : (t < 32) ? 3'd1 : (t < 42) ? 3'd2 :
                      (t < 52) ? 3'd3 : (t < 62) ? 3'd4 : 3'd0;
            exp_ps  = (t == 10) || (t == 12) || (t == 22) || (t == 32) || (t == 42) ||
                      (t == 52) || (t == 62) || (t == 64);
            total_cnt++;
            if (counter !== exp_cnt)
                $display("FAIL ext.counter t=%0d got=%0d exp=%0d", t, counter, exp_cnt);
            else pass_cnt++;
            total_cnt++;
            if (ext_cnt !== exp_ext)
                $display("FAIL ext.ext_cnt t=%0d got=%0d exp=%0d", t, ext_cnt, exp_ext);
            else pass_cnt++;
            total_cnt++;
            if (phase_start !== exp_ps)
                $display("FAIL ext.phase_start t=%0d got=%0b exp=%0b", t, phase_start, exp_ps);
            else pass_cnt++;
            total_cnt++;
            if (car_num !== 32'd20)
                $display("FAIL ext.car_num t=%0d got=%0d exp=20", t, car_num);
            else pass_cnt++;
        end
        tick = 1'b0;
    endtask

    task automatic test_threshold();
        do_reset(32'd10);
        tick = 1'b1;
        // Second GRN: entered at edge 36, final tick at edge 46; 11 arrives one edge before.
        for (int t = 1; t <= 46; t++) begin
            if (t == 45) car_num_in = 32'd11;
            step();
            if (t == 21) begin
                total_cnt++;
                if (counter !== 32'd2) $display("FAIL thr.grn_hold got=%0d exp=2", counter);
                else pass_cnt++;
            end
            if (t == 22) begin
                total_cnt++;
                if (counter !== 32'd3) $display("FAIL thr.no_ext_cnt got=%0d exp=3", counter);
                else pass_cnt++;
                total_cnt++;
                if (ext_cnt !== 3'd0) $display("FAIL thr.no_ext got=%0d exp=0", ext_cnt);
                else pass_cnt++;
            end
            if (t == 45) begin
                total_cnt++;
                if (car_num !== 32'd11) $display("FAIL thr.car_num got=%0d exp=11", car_num);
                else pass_cnt++;
                total_cnt++;
                if (ext_cnt !== 3'd0) $display("FAIL thr.pre_ext got=%0d exp=0", ext_cnt);
                else pass_cnt++;
            end
            if (t == 46) begin
                total_cnt++;
                if (counter !== 32'd6) $display("FAIL thr.ext_counter got=%0d exp=6", counter);
                else pass_cnt++;
                total_cnt++;
                if (ext_cnt !== 3'd1) $display("FAIL thr.ext_cnt got=%0d exp=1", ext_cnt);
                else pass_cnt++;
                total_cnt++;
                if (phase_start !== 1'b1) $display("FAIL thr.ext_pulse got=%0b exp=1", phase_start);
                else pass_cnt++;
            end
        end
        tick       = 1'b0;
        car_num_in = 32'd0;
    endtask

    task automatic test_sensor();
        logic [31:0] exp_cnt;
        logic        exp_ls;
        do_reset(32'd0);
        // YEL1 spans edges 11..14 with a tick gap at 12,13 to show the latch is sticky.
        for (int t = 1; t <= 15; t++) begin
            tick        = !((t == 12) || (t == 13));
            line_sen_in = (t == 5) || (t == 11) || (t == 14) || (t == 15);
            step();
            exp_cnt = (t < 10) ? 32'd0 : (t < 14) ? 32'd1 : 32'd2;
            exp_ls  = (t >= 11) && (t <= 13);
            total_cnt++;
            if (line_sen !== exp_ls)
                $display("FAIL sen.line_sen t=%0d got=%0b exp=%0b", t, line_sen, exp_ls);
            else pass_cnt++;
            total_cnt++;
            if (counter !== exp_cnt)
                $display("FAIL sen.counter t=%0d got=%0d exp=%0d", t, counter, exp_cnt);
            else pass_cnt++;
        end
        tick        = 1'b0;
        line_sen_in = 1'b0;
    endtask

    task automatic test_gating();
        logic [31:0] exp_car;
        logic [31:0] exp_cnt;
        logic        exp_ps;
        do_reset(32'd0);
        exp_car = 32'd0;
        // Ticks every 5th cycle; the tick at cycle 25 falls in the disabled window.
        for (int c = 1; c <= 56; c++) begin
            tick        = (c % 5 == 0);
            enable      = !((c >= 21) && (c <= 27));
            car_num_in  = 32'(c);
            line_sen_in = 1'b1;
            step();
            if (enable) exp_car = 32'(c);
            exp_cnt = (c >= 55) ? 32'd1 : 32'd0;
            exp_ps  = (c == 55);
            total_cnt++;
            if (counter !== exp_cnt)
                $display("FAIL gate.counter c=%0d got=%0d exp=%0d", c, counter, exp_cnt);
            else pass_cnt++;
            total_cnt++;
            if (phase_start !== exp_ps)
                $display("FAIL gate.phase_start c=%0d got=%0b exp=%0b", c, phase_start, exp_ps);
            else pass_cnt++;
            total_cnt++;
            if (car_num !== exp_car)
                $display("FAIL gate.car_num c=%0d got=%0d exp=%0d", c, car_num, exp_car);
            else pass_cnt++;
        end
        tick        = 1'b0;
        enable      = 1'b1;
        line_sen_in = 1'b0;
        car_num_in  = 32'd0;
    endtask

    task automatic test_reset_mid_grn();
        logic [31:0] exp_cnt;
        do_reset(32'd20);
        tick = 1'b1;
        for (int t = 1; t <= 34; t++) step();
        total_cnt++;
        if (ext_cnt !== 3'd2) $display("FAIL rst.pre_ext got=%0d exp=2", ext_cnt);
        else pass_cnt++;
        total_cnt++;
        if (counter !== 32'd2) $display("FAIL rst.pre_counter got=%0d exp=2", counter);
        else pass_cnt++;
        rst_n       = 1'b0;
        line_sen_in = 1'b1;
        #1;
        total_cnt++;
        if (counter !== 32'd0) $display("FAIL rst.async_counter got=%0d exp=0", counter);
        else pass_cnt++;
        total_cnt++;
        if (ext_cnt !== 3'd0) $display("FAIL rst.async_ext got=%0d exp=0", ext_cnt);
        else pass_cnt++;
        total_cnt++;
        if (car_num !== 32'd0) $display("FAIL rst.async_car got=%0d exp=0", car_num);
        else pass_cnt++;
        total_cnt++;
        if (line_sen !== 1'b0) $display("FAIL rst.async_line_sen got=%0b exp=0", line_sen);
        else pass_cnt++;
        step();
        step();
        step();
        rst_n       = 1'b1;
        line_sen_in = 1'b0;
        for (int t = 1; t <= 10; t++) begin
            step();
            exp_cnt = (t < 10) ? 32'd0 : 32'd1;
            total_cnt++;
            if (counter !== exp_cnt)
                $display("FAIL rst.restart t=%0d got=%0d exp=%0d", t, counter, exp_cnt);
            else pass_cnt++;
            total_cnt++;
            if (ext_cnt !== 3'd0) $display("FAIL rst.ext t=%0d got=%0d exp=0", t, ext_cnt);
            else pass_cnt++;
        end
        total_cnt++;
        if (car_num !== 32'd20) $display("FAIL rst.car_resume got=%0d exp=20", car_num);
        else pass_cnt++;
        tick = 1'b0;
    endtask

    initial begin
        rst_n       = 1'b0;
        tick        = 1'b0;
        enable      = 1'b0;
        car_num_in  = 32'd0;
        line_sen_in = 1'b0;
        test_reset();
        test_base_cycle();
        test_ext_cap();
        test_threshold();
        test_sensor();
        test_gating();
        test_reset_mid_grn();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
